// File: rtl/voice_osc.sv
// voice_osc: four independent square-wave voices, summed into a 0..4
// level that feeds a 4-slot PWM audio bit. Each voice holds each level
// for exactly period_i clock cycles; period_i = 0 keeps the voice silent.
module voice_osc #(
   parameter logic [31:0] CLOCK_SPEED = 32'd25_000_000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [31:0] period0,
   input  logic [31:0] period1,
   input  logic [31:0] period2,
   input  logic [31:0] period3,
   output logic [3:0]  square,
   output logic [2:0]  level,
   output logic        pwm_out
);

   logic [31:0] w_period [4];
   logic [31:0] r_cnt    [4];
   logic [3:0]  r_sq;
   logic [2:0]  r_level;
   logic [1:0]  r_pwmCnt;
   logic [2:0]  r_duty;

   assign w_period[0] = period0;
   assign w_period[1] = period1;
   assign w_period[2] = period2;
   assign w_period[3] = period3;

   // Per-voice half-period counters; >= compare lets a shrinking period toggle at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            r_cnt[i] <= 32'd0;
         end
         r_sq <= 4'b0000;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (!enable || (w_period[i] == 32'd0)) begin
               r_cnt[i] <= 32'd0;
               r_sq[i]  <= 1'b0;
            end else if (r_cnt[i] >= (w_period[i] - 32'd1)) begin
               r_cnt[i] <= 32'd0;
               r_sq[i]  <= ~r_sq[i];
            end else begin
               r_cnt[i] <= r_cnt[i] + 32'd1;
            end
         end
      end
   end

   // Mixer: count of voices currently high, one cycle behind the square bits
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_level <= 3'd0;
      end else begin
         r_level <= {2'b00, r_sq[0]} + {2'b00, r_sq[1]}
                  + {2'b00, r_sq[2]} + {2'b00, r_sq[3]};
      end
   end

   // PWM frame counter runs regardless of enable; duty is latched only at frame end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pwmCnt <= 2'd0;
         r_duty   <= 3'd0;
      end else begin
         r_pwmCnt <= r_pwmCnt + 2'd1;
         if (r_pwmCnt == 2'd3) begin
            r_duty <= r_level;
         end
      end
   end

   assign square  = r_sq;
   assign level   = r_level;
   assign pwm_out = ({1'b0, r_pwmCnt} < r_duty);

endmodule
